voice_mixer: RTL and testbench
==============================

# voice_mixer

Upstream sequencer and downstream accumulator for the shared `multiplier` block. The block latches one sample frame of `NUM_VOICES` signed voice samples and unsigned gains, and issues one multiply per voice through the multiplier's trigger/ready/done handshake. It sums the signed products and emits one saturated mix sample per frame to the output stage.

## Interface
- `C_WIDTH`, 16: sample, gain and product width; must equal the attached multiplier's `C_WIDTH`.
- `NUM_VOICES`, 4: voices per frame, ≥1.
- `ACC_WIDTH`, `C_WIDTH+$clog2(NUM_VOICES)+1`: signed accumulator width, derived, never overridden.
- `ctl_clk` in 1: the single clock; all registers on rising edge.
- `reset` in 1: asynchronous, active-high; clears every register.
- `start` in 1: frame strobe, sampled only in IDLE.
- `samples` in `C_WIDTH*NUM_VOICES`: voice i at `[i*C_WIDTH +: C_WIDTH]`, two's complement.
- `gains` in `C_WIDTH*NUM_VOICES`: same packing, unsigned.
- `mul_a` out `C_WIDTH`: operand a (sample magnitude), registered.
- `mul_b` out `C_WIDTH`: operand b (gain), registered.
- `mul_trigger` out 1: multiply request.
- `mul_ready` in 1: multiplier idle.
- `mul_done` in 1: multiplier result valid.
- `mul_y` in `C_WIDTH`: unsigned product, already scaled by the multiplier's `FIXED_POINT`.
- `mix_out` out `C_WIDTH`: saturated signed mix, registered.
- `mix_valid` out 1: one-cycle pulse, `mix_out` updated.
- `busy` out 1: high outside IDLE.

## Operation
- **Reset values:** state IDLE. `mul_a`, `mul_b`, `mix_out`, accumulator and voice index are 0. `mul_trigger`, `mix_valid` and `busy` are 0.
- **IDLE, on `start`=1:**
  - Latch `samples`, `gains` and the sign bit of each sample.
  - Clear the accumulator and set index 0.
  - Go to ISSUE.
  - `start` in any other state is ignored.
- **ISSUE:**
  - `mul_a` = |sample[idx]|. For −2^(C_WIDTH−1) this is 2^(C_WIDTH−1), which fits unsigned.
  - `mul_b` = gain[idx]. Both are loaded on the edge entering ISSUE and held through WAIT.
  - `mul_trigger` = (state==ISSUE) && `mul_ready`, combinational.
  - If `mul_ready`=1, go to WAIT and clear the `armed` flag. Otherwise stay in ISSUE with operands stable.
- **WAIT:**
  - `armed` sets on the first cycle `mul_done`=0. The result is accepted only on a cycle with `armed`=1 and `mul_done`=1, so a stale level-high `done` from the previous op is never consumed twice.
  - On accept: acc += sign[idx] ? −{0,`mul_y`} : {0,`mul_y`}, sign-extended to `ACC_WIDTH`.
  - If idx < `NUM_VOICES`−1: idx++ and go to ISSUE.
  - Else: `mix_out` = sat(acc + final product), assert `mix_valid` and go to IDLE, all on the same edge.
- **Saturation:** clamp to [−2^(C_WIDTH−1), 2^(C_WIDTH−1)−1].
- **Reset mid-frame:** the frame is abandoned with no `mix_valid`. The multiplier shares `reset`.

## Timing
- `start` edge to the first `mul_trigger`: 1 cycle, if `mul_ready`.
- Per voice: 1 ISSUE cycle plus R extra ISSUE cycles while `mul_ready`=0, plus W WAIT cycles up to and including the accept cycle.
- `mix_valid` is high in the cycle after the last accept. The next `start` is accepted in that same cycle.
- Frame latency: 1 + Σ(1+R_i+W_i) cycles.
- `busy` deasserts on the same edge `mix_valid` asserts.

## Configuration
- `VOICE_MIXER_OVERRUN_EN`
- **Defined:** adds output port `overrun` (1 bit, reset 0). It is a sticky flag set when `start`=1 while `busy`=1, and cleared only by `reset`.
- **Undefined:** no port and no logic; a `start` while busy is silently dropped.

## Test plan
- **Mixed-sign sum:** `C_WIDTH`=8, `NUM_VOICES`=4, multiplier `FIXED_POINT`=0. samples {3,−2,1,0}, gains {2,5,4,9} → `mix_out`=0x00, exactly one `mix_valid` pulse, 4 `mul_trigger` pulses.
- **Saturation:**
  - All samples 127, gains 2 → `mix_out`=0x7F.
  - All samples −128, gains 1 → `mix_out`=0x80.
- **Ready back-pressure:** hold `mul_ready`=0 for 5 cycles after `start` → no trigger and `mul_a`/`mul_b` stable. The result matches the unstalled run, with latency +5.
- **Stale done:** multiplier model holds `mul_done`=1 until 3 cycles after trigger, then pulses → each product is accumulated once. samples {1,1,1,1}, gains {1,1,1,1} → `mix_out`=4.
- **Reset mid-frame:** assert `reset` in WAIT of voice 1 → `busy`=0 and `mix_valid` never pulses. The next frame from test 1 gives 0x00.
- **Start while busy:** pulse `start` mid-frame → ignored and the result is unchanged. `overrun`=1 with `VOICE_MIXER_OVERRUN_EN`; the port is absent without it.

Source files
------------

// File: rtl/voice_mixer_if.sv
// voice_mixer_if
//   Trigger/ready/done handshake between voice_mixer and the shared multiplier.
//   master : sequencer side (drives operands and trigger, receives ready/done/product)
//   slave  : multiplier side
//   Signals:
//     mul_a, mul_b  operands (C_WIDTH, unsigned)
//     mul_trigger   multiply request
//     mul_ready     multiplier idle
//     mul_done      multiplier result valid
//     mul_y         unsigned product, already fixed-point scaled (C_WIDTH)
interface voice_mixer_if #(
  parameter int unsigned C_WIDTH = 16
);
  logic [C_WIDTH-1:0] mul_a;
  logic [C_WIDTH-1:0] mul_b;
  logic               mul_trigger;
  logic               mul_ready;
  logic               mul_done;
  logic [C_WIDTH-1:0] mul_y;

  modport master (
    output mul_a,
    output mul_b,
    output mul_trigger,
    input  mul_ready,
    input  mul_done,
    input  mul_y
  );

  modport slave (
    input  mul_a,
    input  mul_b,
    input  mul_trigger,
    output mul_ready,
    output mul_done,
    output mul_y
  );
endinterface

// File: rtl/voice_mixer.sv
// voice_mixer
//   Latches one frame of NUM_VOICES signed samples and unsigned gains, runs one
//   multiply per voice through the shared multiplier (|sample| * gain), sums the
//   signed products and emits one saturated mix sample per frame.
//   Ports:
//     ctl_clk    clock, rising edge
//     reset      asynchronous, active-high
//     start      frame strobe, sampled only in IDLE
//     samples    NUM_VOICES x C_WIDTH two's complement, voice i at [i*C_WIDTH +: C_WIDTH]
//     gains      NUM_VOICES x C_WIDTH unsigned, same packing
//     mul        multiplier handshake (voice_mixer_if.master)
//     mix_out    saturated signed mix, registered
//     mix_valid  one-cycle pulse when mix_out updates
//     busy       high outside IDLE
//     overrun    sticky start-while-busy flag (only with VOICE_MIXER_OVERRUN_EN)
//   Build option: define VOICE_MIXER_OVERRUN_EN to add the overrun port.
module voice_mixer #(
  parameter int unsigned C_WIDTH    = 16,
  parameter int unsigned NUM_VOICES = 4
) (
  input  logic                          ctl_clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [C_WIDTH*NUM_VOICES-1:0] samples,
  input  logic [C_WIDTH*NUM_VOICES-1:0] gains,
  voice_mixer_if.master                 mul,
  output logic [C_WIDTH-1:0]            mix_out,
  output logic                          mix_valid,
  output logic                          busy
`ifdef VOICE_MIXER_OVERRUN_EN
  ,
  output logic                          overrun
`endif
);

  localparam int unsigned ACC_WIDTH = C_WIDTH + $clog2(NUM_VOICES) + 1;
  localparam int unsigned IDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'((64'd1 << (C_WIDTH - 1)) - 64'd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [C_WIDTH*NUM_VOICES-1:0] samp_q;
  logic [C_WIDTH*NUM_VOICES-1:0] gain_q;
  logic [NUM_VOICES-1:0]         sign_q;
  logic signed [ACC_WIDTH-1:0]   acc_q;
  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic signed [ACC_WIDTH-1:0]   acc_sum;
  logic [C_WIDTH-1:0]            sat_val;
  logic [IDX_W-1:0]              idx_q;
  logic [IDX_W-1:0]              idx_nxt;
  logic                          armed_q;
  logic                          accept;

  // Magnitude of a two's complement sample; the most negative value maps to
  // 2^(C_WIDTH-1), which is representable as unsigned.
  function automatic logic [C_WIDTH-1:0] mag(input logic [C_WIDTH-1:0] s);
    return s[C_WIDTH-1] ? (~s + C_WIDTH'(1)) : s;
  endfunction

  assign idx_nxt  = idx_q + IDX_W'(1);
  assign prod_ext = {{(ACC_WIDTH - C_WIDTH){1'b0}}, mul.mul_y};
  assign acc_sum  = sign_q[idx_q] ? (acc_q - prod_ext) : (acc_q + prod_ext);
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    if (acc_sum > SAT_MAX)
      sat_val = {1'b0, {(C_WIDTH - 1){1'b1}}};
    else if (acc_sum < SAT_MIN)
      sat_val = {1'b1, {(C_WIDTH - 1){1'b0}}};
    else
      sat_val = acc_sum[C_WIDTH-1:0];
  end

  always_ff @(posedge ctl_clk or posedge reset) begin
    if (reset)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // A result is taken only once done has been seen low since the trigger
  // (armed_q), so a level-high done left over from the previous op is skipped.
  always_comb begin
    state_d         = state_q;
    mul.mul_trigger = 1'b0;
    accept          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start)
          state_d = S_ISSUE;
      end
      S_ISSUE: begin
        mul.mul_trigger = mul.mul_ready;
        if (mul.mul_ready)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        accept = armed_q & mul.mul_done;
        if (accept)
          state_d = (idx_q == LAST_IDX) ? S_IDLE : S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operands are loaded on the edge entering ISSUE: from the live inputs at
  // frame start, from the latched frame when advancing to the next voice.
  always_ff @(posedge ctl_clk or posedge reset) begin
    if (reset) begin
      samp_q    <= '0;
      gain_q    <= '0;
      sign_q    <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      armed_q   <= 1'b0;
      mul.mul_a <= '0;
      mul.mul_b <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            samp_q <= samples;
            gain_q <= gains;
            for (int unsigned i = 0; i < NUM_VOICES; i++)
              sign_q[i] <= samples[i*C_WIDTH + C_WIDTH - 1];
            acc_q     <= '0;
            idx_q     <= '0;
            mul.mul_a <= mag(samples[0 +: C_WIDTH]);
            mul.mul_b <= gains[0 +: C_WIDTH];
          end
        end
        S_ISSUE: begin
          if (mul.mul_ready)
            armed_q <= 1'b0;
        end
        S_WAIT: begin
          if (!mul.mul_done)
            armed_q <= 1'b1;
          if (accept) begin
            acc_q <= acc_sum;
            if (idx_q != LAST_IDX) begin
              idx_q     <= idx_nxt;
              mul.mul_a <= mag(samp_q[idx_nxt*C_WIDTH +: C_WIDTH]);
              mul.mul_b <= gain_q[idx_nxt*C_WIDTH +: C_WIDTH];
            end else begin
              mix_out   <= sat_val;
              mix_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef VOICE_MIXER_OVERRUN_EN
  always_ff @(posedge ctl_clk or posedge reset) begin
    if (reset)
      overrun <= 1'b0;
    else if (start && busy)
      overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer
//   Self-checking bench for voice_mixer (C_WIDTH=8, NUM_VOICES=4) with a
//   behavioural multiplier (FIXED_POINT=0) on the slave side of voice_mixer_if.
module tb_voice_mixer;
  localparam int CW = 8;
  localparam int NV = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   samples;
  logic [31:0]   gains;
  logic [7:0]    mix_out;
  logic          mix_valid;
  logic          busy;
`ifdef VOICE_MIXER_OVERRUN_EN
  logic          overrun;
`endif

  voice_mixer_if #(.C_WIDTH(CW)) mif ();

  voice_mixer #(.C_WIDTH(CW), .NUM_VOICES(NV)) dut (
    .ctl_clk  (clk),
    .reset    (rst),
    .start    (start),
    .samples  (samples),
    .gains    (gains),
    .mul      (mif),
    .mix_out  (mix_out),
    .mix_valid(mix_valid),
    .busy     (busy)
`ifdef VOICE_MIXER_OVERRUN_EN
    ,
    .overrun  (overrun)
`endif
  );

  always #5 clk = ~clk;

  // Multiplier model. Normal: done pulses 2 edges after trigger.
  // Stale mode: done stays high (old result) for 3 cycles after trigger,
  // drops for one cycle, then rises with the new product and stays high.
  logic        m_busy, m_done, stale_mode, ready_block;
  logic [7:0]  m_y, m_a, m_b;
  logic [15:0] m_full;
  int          m_cnt;
  assign m_full          = m_a * m_b;
  assign mif.mul_ready   = !m_busy && !ready_block;
  assign mif.mul_done    = m_done;
  assign mif.mul_y       = m_y;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_y <= '0; m_cnt <= 0; m_a <= '0; m_b <= '0;
    end else if (mif.mul_trigger) begin
      m_busy <= 1'b1; m_cnt <= 0; m_a <= mif.mul_a; m_b <= mif.mul_b;
      if (!stale_mode) m_done <= 1'b0;
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (!stale_mode) begin
        if (m_cnt == 1) begin m_done <= 1'b1; m_y <= m_full[7:0]; m_busy <= 1'b0; end
      end else begin
        if (m_cnt == 2) m_done <= 1'b0;
        if (m_cnt == 3) begin m_done <= 1'b1; m_y <= m_full[7:0]; m_busy <= 1'b0; end
      end
    end else if (!stale_mode && m_done) begin
      m_done <= 1'b0;
    end else if (stale_mode && !m_done) begin
      m_done <= 1'b1; m_y <= 8'h55;
    end
  end

  int n_tests = 0, n_fail = 0;
  int cyc = 0, trig_cnt = 0, mix_cnt = 0, last_mix_cyc = 0;
  int t0, tr0, mc0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard side: every mix_valid pops one expected mix sample.
  always @(negedge clk) begin
    if (!rst) begin
      if (mif.mul_trigger) trig_cnt++;
      if (mix_valid) begin
        mix_cnt++;
        last_mix_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_mix_valid: got mix_out %0h expected no pulse", mix_out);
        end else begin
          chk("mix_out", {24'd0, mix_out}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic launch(input logic [31:0] s, input logic [31:0] g,
                        input logic [7:0] e, input bit push);
    @(negedge clk);
    samples = s; gains = g; start = 1'b1;
    if (push) exp_q.push_back(e);
    t0 = cyc; tr0 = trig_cnt; mc0 = mix_cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_frame(input string nm, input int lat);
    for (int i = 0; i < 300 && mix_cnt == mc0; i++) @(negedge clk);
    if (mix_cnt == mc0) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got no mix_valid expected one within 300 cycles", nm);
    end
    repeat (3) @(negedge clk);
    chk({nm, "_pulses"}, mix_cnt - mc0, 1);
    chk({nm, "_latency"}, last_mix_cyc - t0, lat);
    chk({nm, "_triggers"}, trig_cnt - tr0, NV);
    chk({nm, "_busy_after"}, {31'd0, busy}, 0);
  endtask

  typedef struct {
    logic [31:0] s;
    logic [31:0] g;
    logic [7:0]  e;
  } vec_t;
  vec_t vecs[5];

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // samples packed voice3..voice0; expected = sat(sum sign_i*|s_i|*g_i)
    vecs[0] = '{32'h0001FE03, 32'h09040502, 8'h00}; // {3,-2,1,0}*{2,5,4,9} = 0
    vecs[1] = '{32'h7F7F7F7F, 32'h02020202, 8'h7F}; // 1016 -> clamp high
    vecs[2] = '{32'h80808080, 32'h01010101, 8'h80}; // -512 -> clamp low
    vecs[3] = '{32'h07FD0AFB, 32'h01010203, 8'h09}; // -15+20-3+7 = 9
    vecs[4] = '{32'h0000329C, 32'h00000101, 8'hCE}; // -100+50 = -50

    rst = 1'b1; start = 1'b0; samples = '0; gains = '0;
    stale_mode = 1'b0; ready_block = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_mix_valid", {31'd0, mix_valid}, 0);
    chk("rst_mix_out", {24'd0, mix_out}, 0);
    chk("rst_trigger", {31'd0, mif.mul_trigger}, 0);
    chk("rst_mul_a", {24'd0, mif.mul_a}, 0);
    chk("rst_mul_b", {24'd0, mif.mul_b}, 0);
`ifdef VOICE_MIXER_OVERRUN_EN
    chk("rst_overrun", {31'd0, overrun}, 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table-driven frames, unstalled: latency 1 + 4*(1+0+3) = 17
    for (int k = 0; k < 5; k++) begin
      launch(vecs[k].s, vecs[k].g, vecs[k].e, 1'b1);
      finish_frame("vec", 17);
    end

    // Ready back-pressure for 5 ISSUE cycles: same result, latency +5
    @(negedge clk);
    samples = vecs[0].s; gains = vecs[0].g; start = 1'b1; ready_block = 1'b1;
    exp_q.push_back(8'h00);
    t0 = cyc; tr0 = trig_cnt; mc0 = mix_cnt;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_no_trigger", {31'd0, mif.mul_trigger}, 0);
      chk("stall_mul_a", {24'd0, mif.mul_a}, 3);
      chk("stall_mul_b", {24'd0, mif.mul_b}, 2);
      @(negedge clk);
    end
    ready_block = 1'b0;
    finish_frame("stall", 22);

    // Stale level-high done: each product counted once, 1 + 4*(1+0+5) = 25
    stale_mode = 1'b1;
    repeat (3) @(negedge clk);
    launch(32'h01010101, 32'h01010101, 8'h04, 1'b1);
    finish_frame("stale", 25);
    stale_mode = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in WAIT of voice 1: frame abandoned, no mix_valid
    launch(vecs[0].s, vecs[0].g, 8'h00, 1'b0);
    for (int i = 0; i < 50 && trig_cnt < tr0 + 2; i++) @(negedge clk);
    @(negedge clk);
    chk("rstmid_in_wait_busy", {31'd0, busy}, 1);
    chk("rstmid_in_wait_trig", {31'd0, mif.mul_trigger}, 0);
    chk("rstmid_voice1_mul_a", {24'd0, mif.mul_a}, 2);
    rst = 1'b1;
    #1;
    chk("rstmid_busy", {31'd0, busy}, 0);
    chk("rstmid_mix_valid", {31'd0, mix_valid}, 0);
    chk("rstmid_mix_out", {24'd0, mix_out}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("rstmid_no_pulse", mix_cnt - mc0, 0);
    launch(vecs[0].s, vecs[0].g, vecs[0].e, 1'b1);
    finish_frame("after_rst", 17);

    // Start while busy: ignored, result and timing unchanged
    launch(vecs[3].s, vecs[3].g, vecs[3].e, 1'b1);
    for (int i = 0; i < 50 && trig_cnt < tr0 + 2; i++) @(negedge clk);
    @(negedge clk);
    chk("busy_start_busy", {31'd0, busy}, 1);
    samples = 32'h7F7F7F7F; gains = 32'h02020202; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_frame("busy_start", 17);
`ifdef VOICE_MIXER_OVERRUN_EN
    chk("overrun_set", {31'd0, overrun}, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
